bk_addsub_pipe: RTL and testbench

- Pipelined, handshaked Brent-Kung add/subtract unit built around the same generate/propagate prefix-tree structure as brent_kung_adder_nbit.
- Adds the subtract direction (two's-complement with borrow-in), registers the prefix tree over 3 stages, and uses valid/ready flow control on input and output.
- Used as the arithmetic slice in datapaths where a single-cycle N-bit carry chain misses timing.

---
 rtl/bk_addsub_pipe.sv | 172 +++++++++++++++++
 tb/tb_bk_addsub_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_addsub_pipe.sv
// rtl/bk_addsub_pipe.sv - pipelined handshaked Brent-Kung add/subtract unit
//
// Three register stages. S1 holds the conditioned operands, S2 the Brent-Kung
// up-sweep, and the output register holds the down-sweep result and flags.
// The pipeline advances when the output is empty or being taken.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready = !out_valid || out_ready)
//   in_op1, in_op2        operands A and B (ADDER_SIZE bits)
//   in_sub                0 = A + B + cin, 1 = A - B - cin
//   in_cin                carry-in (add) or borrow-in (sub)
//   out_valid / out_ready output handshake
//   out_res               result modulo 2^ADDER_SIZE
//   out_cout              carry-out (add) or borrow-out (sub)
//   out_ovf               signed two's-complement overflow
//   out_zero              out_res == 0
module bk_addsub_pipe #(
    parameter int ADDER_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDER_SIZE-1:0] in_op1,
    input  logic [ADDER_SIZE-1:0] in_op2,
    input  logic                  in_sub,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDER_SIZE-1:0] out_res,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic                  out_zero
);

    localparam int N = ADDER_SIZE;
    localparam int L = $clog2(N);

    // Up-sweep: node i (i+1 a multiple of 2^l) absorbs the span just below it.
    // Afterwards node 2^k-1 holds the full prefix [2^k-1:0].
    function automatic logic [2*N-1:0] up_sweep(input logic [N-1:0] g_in,
                                                 input logic [N-1:0] p_in);
        logic [N-1:0] g;
        logic [N-1:0] p;
        g = g_in;
        p = p_in;
        for (int l = 1; l <= L; l++) begin
            for (int i = 0; i < N; i++) begin
                if (((i + 1) % (1 << l)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << (l - 1))]);
                    p[i] = p[i] & p[i - (1 << (l - 1))];
                end
            end
        end
        return {g, p};
    endfunction

    // Down-sweep: fill the remaining positions top-down from the finished prefixes.
    function automatic logic [N-1:0] down_sweep(input logic [N-1:0] g_in,
                                                input logic [N-1:0] p_in);
        logic [N-1:0] g;
        g = g_in;
        for (int l = L - 1; l >= 1; l--) begin
            for (int i = 0; i < N; i++) begin
                if ((((i + 1) % (1 << l)) == 0) && ((i + (1 << (l - 1))) < N)) begin
                    g[i + (1 << (l - 1))] = g[i + (1 << (l - 1))]
                                          | (p_in[i + (1 << (l - 1))] & g[i]);
                end
            end
        end
        return g;
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage S1 inputs: conditioned operand and effective carry-in
    logic [N-1:0] b_cond;
    logic [N-1:0] g_raw;
    logic [N-1:0] p_raw;
    logic         c0;

    assign b_cond = in_sub ? ~in_op2 : in_op2;
    assign c0     = in_sub ? ~in_cin : in_cin;
    assign g_raw  = in_op1 & b_cond;
    assign p_raw  = in_op1 ^ b_cond;

    logic         s1_valid;
    logic [N-1:0] s1_g;
    logic [N-1:0] s1_p;
    logic         s1_c0;
    logic         s1_a_msb;
    logic         s1_b_msb;
    logic         s1_sub;

    logic         s2_valid;
    logic [N-1:0] s2_g;
    logic [N-1:0] s2_pg;
    logic [N-1:0] s2_p;
    logic         s2_c0;
    logic         s2_a_msb;
    logic         s2_b_msb;
    logic         s2_sub;

    logic [N-1:0] up_g;
    logic [N-1:0] up_p;
    assign {up_g, up_p} = up_sweep(s1_g, s1_p);

    // Carry into bit i+1 is prefix G[i]; c0 is already folded into bit 0.
    logic [N-1:0] carries;
    logic [N-1:0] sum;
    logic         c_raw;
    assign carries = down_sweep(s2_g, s2_pg);
    assign sum     = s2_p ^ {carries[N-2:0], s2_c0};
    assign c_raw   = carries[N-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_g      <= '0;
            s1_p      <= '0;
            s1_c0     <= 1'b0;
            s1_a_msb  <= 1'b0;
            s1_b_msb  <= 1'b0;
            s1_sub    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_g      <= '0;
            s2_pg     <= '0;
            s2_p      <= '0;
            s2_c0     <= 1'b0;
            s2_a_msb  <= 1'b0;
            s2_b_msb  <= 1'b0;
            s2_sub    <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                // Folding c0 into g[0] makes every group generate include the carry-in.
                s1_g     <= {g_raw[N-1:1], g_raw[0] | (p_raw[0] & c0)};
                s1_p     <= p_raw;
                s1_c0    <= c0;
                s1_a_msb <= in_op1[N-1];
                s1_b_msb <= b_cond[N-1];
                s1_sub   <= in_sub;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_g     <= up_g;
                s2_pg    <= up_p;
                s2_p     <= s1_p;
                s2_c0    <= s1_c0;
                s2_a_msb <= s1_a_msb;
                s2_b_msb <= s1_b_msb;
                s2_sub   <= s1_sub;
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_res  <= sum;
                out_cout <= s2_sub ? ~c_raw : c_raw;
                out_ovf  <= (s2_a_msb == s2_b_msb) && (sum[N-1] != s2_a_msb);
                out_zero <= (sum == '0);
            end
        end
    end

endmodule

// File: tb/tb_bk_addsub_pipe.sv
// tb/tb_bk_addsub_pipe.sv - self-checking bench for bk_addsub_pipe
module tb_bk_addsub_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_op1;
    logic [15:0] in_op2;
    logic        in_sub;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    bk_addsub_pipe #(.ADDER_SIZE(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    // width-sweep instances at 4, 32 and 128 bits, driven in lockstep
    logic         sw_valid;
    logic [127:0] sw_a;
    logic [127:0] sw_b;
    logic         sw_sub;
    logic         sw_cin;
    logic [2:0]   sw_rdy;
    logic [2:0]   sw_ov;
    logic [2:0]   sw_co;
    logic [2:0]   sw_of;
    logic [2:0]   sw_z;
    logic [127:0] sw_res [3];

    for (genvar k = 0; k < 3; k++) begin : g_w
        localparam int W = (k == 0) ? 4 : ((k == 1) ? 32 : 128);
        logic [W-1:0] r;
        bk_addsub_pipe #(.ADDER_SIZE(W)) u (
            .clk(clk), .rst(rst),
            .in_valid(sw_valid), .in_ready(sw_rdy[k]),
            .in_op1(sw_a[W-1:0]), .in_op2(sw_b[W-1:0]), .in_sub(sw_sub), .in_cin(sw_cin),
            .out_valid(sw_ov[k]), .out_ready(1'b1),
            .out_res(r), .out_cout(sw_co[k]), .out_ovf(sw_of[k]), .out_zero(sw_z[k])
        );
        assign sw_res[k] = 128'(r);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit sb_on = 0;
    logic [130:0] sbq [$];

    task automatic check(input string name, input logic [130:0] act, input logic [130:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, zero, cout, res[127:0]}
    function automatic logic [130:0] model(input int w, input logic [127:0] a,
                                           input logic [127:0] b, input logic sub,
                                           input logic cin);
        logic [129:0] mask, ua, ub, us;
        logic [127:0] res;
        logic cout, ovf, zero;
        logic signed [131:0] sa, sb, sc, sr, lim;
        mask = (130'd1 << w) - 130'd1;
        ua = {2'b0, a} & mask;
        ub = {2'b0, b} & mask;
        if (!sub) begin
            us = ua + ub + {129'd0, cin};
            cout = us[w];
        end else begin
            us = ua - ub - {129'd0, cin};
            cout = (ua < ub + {129'd0, cin});
        end
        res = us[127:0] & mask[127:0];
        zero = (res == 128'd0);
        sa = $signed({2'b0, ua});
        if (ua[w-1]) sa = sa - $signed({2'b0, 130'd1 << w});
        sb = $signed({2'b0, ub});
        if (ub[w-1]) sb = sb - $signed({2'b0, 130'd1 << w});
        sc = cin ? 132'sd1 : 132'sd0;
        sr = sub ? (sa - sb - sc) : (sa + sb + sc);
        lim = $signed({2'b0, 130'd1 << (w - 1)});
        ovf = (sr >= lim) || (sr < -lim);
        return {ovf, zero, cout, res};
    endfunction

    function automatic logic [130:0] dut_out();
        return {out_ovf, out_zero, out_cout, 112'd0, out_res};
    endfunction

    // One clock: scoreboard the transfers that happen at the coming edge.
    task automatic tick();
        logic [130:0] e;
        #1;
        if (sb_on) begin
            if (in_valid && in_ready)
                sbq.push_back(model(16, 128'(in_op1), 128'(in_op2), in_sub, in_cin));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) check("unexpected_output", 131'd1, 131'd0);
                else begin
                    e = sbq.pop_front();
                    check("stream_result", dut_out(), e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        in_op1 = 16'($urandom);
        in_op2 = 16'($urandom);
        in_sub = 1'($urandom);
        in_cin = 1'($urandom);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t tab [10];
    logic [130:0] snap;
    logic [130:0] exp_tab [3][104];
    int cnt [3];
    int widths [3];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tab[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tab[1] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        tab[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        tab[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tab[4] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0};
        tab[5] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tab[6] = '{16'h0005, 16'h0004, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        tab[7] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tab[8] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tab[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        widths = '{4, 32, 128};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_op1 = '0; in_op2 = '0; in_sub = 1'b0; in_cin = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 131'(out_valid), 131'd0);
        check("reset_outputs", dut_out(), 131'd0);
        check("reset_in_ready", 131'(in_ready), 131'd1);

        // directed vectors, one at a time, with latency check
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_op1 = tab[i].a; in_op2 = tab[i].b; in_sub = tab[i].sub; in_cin = tab[i].cin;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            check("latency_early", 131'(out_valid), 131'd0);
            tick();
            check("latency_valid", 131'(out_valid), 131'd1);
            check("vec_res", 131'(out_res), 131'(tab[i].res));
            check("vec_cout", 131'(out_cout), 131'(tab[i].cout));
            check("vec_ovf", 131'(out_ovf), 131'(tab[i].ovf));
            check("vec_zero", 131'(out_zero), 131'(tab[i].zero));
        end
        tick();

        // streaming: 50 back-to-back bundles
        sb_on = 1;
        for (int c = 0; c < 53; c++) begin
            in_valid = (c < 50);
            rand_in();
            tick();
            check("stream_in_ready", 131'(in_ready), 131'd1);
            check("stream_out_valid", 131'(out_valid), 131'((c >= 2) && (c <= 51)));
        end
        check("stream_drained", 131'(sbq.size()), 131'd0);

        // backpressure: fill, stall 5 cycles, release
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_in();
            tick();
        end
        check("bp_full_valid", 131'(out_valid), 131'd1);
        snap = dut_out();
        for (int c = 0; c < 5; c++) begin
            rand_in();
            tick();
            check("bp_in_ready", 131'(in_ready), 131'd0);
            check("bp_out_valid", 131'(out_valid), 131'd1);
            check("bp_frozen", dut_out(), snap);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6 && sbq.size() > 0; c++) tick();
        check("bp_drained", 131'(sbq.size()), 131'd0);
        tick();
        check("bp_idle", 131'(out_valid), 131'd0);

        // reset mid-flight
        sb_on = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_in();
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_valid", 131'(out_valid), 131'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 131'(out_valid), 131'd0);
        check("rst_outputs", dut_out(), 131'd0);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", 131'(in_ready), 131'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rst_no_stale", 131'(out_valid), 131'd0);
        end

        // width sweep
        cnt = '{0, 0, 0};
        for (int v = 0; v < 107; v++) begin
            if (v < 104) begin
                case (v)
                    0: begin sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_cin = 1'b0; end
                    1: begin sw_a = '1; sw_b = '0; sw_sub = 1'b0; sw_cin = 1'b0; end
                    2: begin sw_a = 128'd1; sw_b = '1; sw_sub = 1'b0; sw_cin = 1'b0; end
                    3: begin sw_a = '0; sw_b = 128'd1; sw_sub = 1'b1; sw_cin = 1'b0; end
                    default: begin
                        sw_a = {$urandom, $urandom, $urandom, $urandom};
                        sw_b = {$urandom, $urandom, $urandom, $urandom};
                        sw_sub = 1'($urandom);
                        sw_cin = 1'($urandom);
                    end
                endcase
                sw_valid = 1'b1;
                for (int k = 0; k < 3; k++)
                    exp_tab[k][v] = model(widths[k], sw_a, sw_b, sw_sub, sw_cin);
            end else begin
                sw_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("sweep_in_ready", 131'(sw_rdy), 131'd7);
            for (int k = 0; k < 3; k++) begin
                if (sw_ov[k]) begin
                    if (cnt[k] < 104)
                        check($sformatf("sweep_w%0d_v%0d", widths[k], cnt[k]),
                              {sw_of[k], sw_z[k], sw_co[k], sw_res[k]}, exp_tab[k][cnt[k]]);
                    cnt[k]++;
                end
            end
        end
        for (int k = 0; k < 3; k++)
            check($sformatf("sweep_w%0d_count", widths[k]), 131'(cnt[k]), 131'd104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
